// File: rtl/wb_commit_trace_pkg.sv
// Shared definitions for the writeback commit filter and trace buffer.
// Record layout helpers used by the block and the trace consumer.
package wb_commit_trace_pkg;

  localparam int SEQ_W = 32;

  function automatic int rec_w(
    input int pc_w,
    input int be_w,
    input int ra_w,
    input int data_w
  );
    return pc_w + be_w + ra_w + data_w + SEQ_W;
  endfunction

endpackage

// File: rtl/wb_commit_trace_if.sv
// Trace port bundle: show-ahead head record with valid/ready handshake.
// master drives the record, slave consumes it.
interface wb_commit_trace_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int RA_W   = 5
);
  import wb_commit_trace_pkg::*;

  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [BE_W-1:0]   wen;
  logic [RA_W-1:0]   wnum;
  logic [DATA_W-1:0] wdata;
  logic [SEQ_W-1:0]  seq;

  modport master (
    output valid, pc, wen, wnum, wdata, seq,
    input  ready
  );

  modport slave (
    input  valid, pc, wen, wnum, wdata, seq,
    output ready
  );

endinterface

// File: rtl/wb_trace_fifo.sv
// Synchronous FIFO with show-ahead output; DEPTH must be a power of two.
// Pointers wrap naturally through their width.
module wb_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem[rptr_q];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din;
  end

endmodule

// File: rtl/wb_commit_trace.sv
// Writeback commit filter: gates regfile enables and queues trace records.
// Define WB_SEQTAG_EN to detect new instructions by wb_tag instead of PC.
module wb_commit_trace
  import wb_commit_trace_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int RA_W   = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [PC_W-1:0]   wb_pc,
  input  logic              wb_regwrite,
  input  logic [RA_W-1:0]   wb_wnum,
  input  logic [DATA_W-1:0] wb_wdata,
`ifdef WB_SEQTAG_EN
  input  logic              wb_tag,
`endif
  output logic [BE_W-1:0]   real_regwrite,
  output logic              stall_req,
  wb_commit_trace_if.master trace
);

  localparam int REC_W = rec_w(PC_W, BE_W, RA_W, DATA_W);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic             first_q, first_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             is_new;
  logic             push_ok;
  logic             commit;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_out;

`ifdef WB_SEQTAG_EN
  logic last_tag_q, last_tag_d;
  logic differs;
  assign differs = (wb_tag != last_tag_q);
`else
  logic differs;
  assign differs = (wb_pc != last_pc_q);
`endif

  assign trace.valid = (fifo_cnt != '0);
  assign pop         = trace.ready & ~fifo_empty;

  always_comb begin
    is_new        = wb_valid & (first_q | differs);
    push_ok       = ~fifo_full | pop;
    commit        = is_new & push_ok;
    stall_req     = is_new & ~push_ok;
    real_regwrite = commit ? {BE_W{wb_regwrite}} : '0;
    last_pc_d     = last_pc_q;
    first_d       = first_q;
    seq_d         = seq_q;
    if (commit) begin
      last_pc_d = wb_pc;
      first_d   = 1'b0;
      seq_d     = seq_q + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc_q <= '0;
      first_q   <= 1'b1;
      seq_q     <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      first_q   <= first_d;
      seq_q     <= seq_d;
    end
  end

`ifdef WB_SEQTAG_EN
  always_comb begin
    last_tag_d = last_tag_q;
    if (commit) last_tag_d = wb_tag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_tag_q <= 1'b0;
    else        last_tag_q <= last_tag_d;
  end
`endif

  assign rec_in = {wb_pc, real_regwrite, wb_wnum, wb_wdata, seq_q};

  wb_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (commit),
    .pop   (pop),
    .din   (rec_in),
    .dout  (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign {trace.pc, trace.wen, trace.wnum, trace.wdata, trace.seq} = rec_out;

endmodule
